sequenced_bus_datapath: RTL
===========================

# sequenced_bus_datapath

Parametrised single-bus CPU datapath with a built-in micro-step sequencer: accepts one register/memory command at a time over a valid/ready handshake. It executes each command as a fixed sequence of bus transfers through Y, the ALU and Z, and talks to external memory through MAR/MDR with a wait-state handshake. It is the next generation of the hand-driven bus datapath, replacing externally sequenced enables with internal control so the control unit only issues commands.

## Interface
- DATA_W, 32, bus/register width
- NUM_REGS, 16, general registers R0..R(NUM_REGS-1); power of two, >= 2
- IMM_W, 19, immediate width, sign-extended to DATA_W
- ADDR_W, 9, memory address width (MAR low ADDR_W bits)
- REG_IDX_W, $clog2(NUM_REGS), derived localparam, not overridable

Ports:
- clock  in  1  sole clock, rising edge
- clear  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_kind  in  2  0 ALU, 1 LOAD, 2 STORE, 3 ADDI
- cmd_op  in  3  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL; 5-7 reserved
- cmd_ra, cmd_rb, cmd_rc  in  REG_IDX_W each  destination/source register indices
- cmd_imm  in  IMM_W  immediate
- mem_addr  out  ADDR_W  MAR[ADDR_W-1:0]
- mem_wdata  out  DATA_W  MDR contents
- mem_rdata  in  DATA_W  read data, sampled when mem_ready
- mem_read, mem_write  out  1  request strobes, held until mem_ready
- mem_ready  in  1  memory completion
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse in the final step of each command
- dbg_sel  in  REG_IDX_W+1  0..NUM_REGS-1 GPR, NUM_REGS HI, NUM_REGS+1 LO, other values read 0
- dbg_data  out  DATA_W  combinational read of dbg_sel

## Operation
- Command captured into internal IR on cmd_valid && cmd_ready.
- Base-address rule: for LOAD/STORE/ADDI, rb==0 reads as zero (BA behaviour). For ALU, R0 reads its stored value. R0 is writable.
- States and per-step bus transfers:
  - IDLE: on accept -> T1.
  - T1: base operand (Rb, or 0 per the base-address rule) -> bus -> Y. -> T2.
  - T2: second operand -> bus, where the operand is Rc for ALU and sext(imm) otherwise. Z <= ALU(Y, bus). LOAD/STORE/ADDI force ADD. -> T3.
  - T3: ALU non-MUL and ADDI: Ra <= Zlo, done, -> IDLE. MUL: HI <= Zhi, LO <= Zlo, Ra unchanged, done, -> IDLE. LOAD/STORE: MAR <= Zlo; STORE also MDR <= Ra. -> MEM.
  - MEM: mem_read (LOAD) or mem_write (STORE) asserted. On mem_ready, LOAD takes MDR <= mem_rdata and goes to T5; STORE pulses done and goes to IDLE.
  - T5: Ra <= MDR, done, -> IDLE.
- Arithmetic: ADD/SUB modulo 2^DATA_W, no flags. AND/OR bitwise. MUL is signed DATA_W x DATA_W -> 2*DATA_W. Non-MUL Zhi = 0. Reserved ops give Z = 0, and 0 is still written to Ra.
- Address = Zlo[ADDR_W-1:0]; upper bits ignored, wrap-around silent.

## Timing
- Reset values: all GPRs, HI, LO, Y, Z, MAR, MDR, IR = 0; state IDLE; cmd_ready = 1; busy, done, mem_read, mem_write = 0. Strobes drop asynchronously on clear, including clear mid-MEM.
- Latency from the accept edge to done, plus wait cycles W: ALU/ADDI 3 cycles; STORE 4 + W; LOAD 5 + W.
- Register results are visible on dbg_data the cycle after done.
- No back-to-back overlap: next accept is earliest in the cycle after done.
- mem_ready outside MEM is ignored. mem_ready in the first MEM cycle gives W = 0.
- mem_addr and mem_wdata are stable for the whole MEM state.
- cmd_* inputs are don't-care while busy.

## Structure
- Package sequenced_bus_pkg: cmd_kind enum, alu_op enum, state enum, dbg HI/LO select offsets.
- Sub-module seq_bus_alu: combinational, parametrised by DATA_W, 2*DATA_W result.
- Top holds the register file, Y/Z/HI/LO/MAR/MDR/IR, the single bus mux, and the FSM.

## Test plan
- Reset then dbg sweep -> all GPR/HI/LO read 0; cmd_ready = 1, strobes 0.
- Preload via ADDI R1 = 5 (rb = 0, imm = 5), ALU SUB R2 = R1 - R1, then R3 = R2 - R1 -> R3 = 0xFFFFFFFB, done 3 cycles after each accept.
- ADDI R4 = -3, ADDI R5 = 7, MUL R4, R5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB, R0 unchanged.
- STORE R5 to [R0 + 0x1FF] with mem_ready delayed 2 cycles -> mem_write held 3 cycles, mem_addr = 0x1FF, mem_wdata = 7, done at cycle 6. LOAD R6 from the same address with mem_rdata = 7 -> R6 = 7.
- Address wrap: LOAD with Rb = 0x200, imm = 1 -> mem_addr = 0x001.
- clear asserted during a MEM wait -> mem_read falls immediately, state IDLE, all registers 0, no done pulse.

Source files
------------

// File: rtl/sequenced_bus_pkg.sv
// Shared encodings for the sequenced single-bus datapath: command kinds,
// ALU opcodes, sequencer states and debug-select offsets for HI/LO.
package sequenced_bus_pkg;

    typedef enum logic [1:0] {
        KIND_ALU   = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_ADDI  = 2'd3
    } cmd_kind_e;

    // Codes 5..7 are reserved and produce a zero result.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_MUL = 3'd4
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_MEM  = 3'd4,
        S_T5   = 3'd5
    } state_e;

    // Debug select values above the GPR range, relative to NUM_REGS.
    localparam int DBG_HI_OFS = 0;
    localparam int DBG_LO_OFS = 1;

endpackage

// File: rtl/seq_bus_alu.sv
// Combinational ALU: Y op bus -> double-width Z. Only MUL fills the upper half;
// reserved opcodes yield zero.
module seq_bus_alu
    import sequenced_bus_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          op_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic [2*DATA_W-1:0] z_o
);

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;

    // The low 2*DATA_W bits of the product of sign-extended operands are the
    // exact signed product, so no signed arithmetic is needed.
    assign a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    assign b_ext = {{DATA_W{b_i[DATA_W-1]}}, b_i};

    always_comb begin
        z_o = '0;
        case (op_i)
            OP_ADD:  z_o = {{DATA_W{1'b0}}, a_i + b_i};
            OP_SUB:  z_o = {{DATA_W{1'b0}}, a_i - b_i};
            OP_AND:  z_o = {{DATA_W{1'b0}}, a_i & b_i};
            OP_OR:   z_o = {{DATA_W{1'b0}}, a_i | b_i};
            OP_MUL:  z_o = a_ext * b_ext;
            default: z_o = '0;
        endcase
    end

endmodule

// File: rtl/sequenced_bus_datapath.sv
// Single-bus datapath with an internal micro-step sequencer: one command at a
// time, executed as Y/ALU/Z bus transfers plus a MAR/MDR memory handshake.
module sequenced_bus_datapath
    import sequenced_bus_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int NUM_REGS  = 16,
    parameter  int IMM_W     = 19,
    parameter  int ADDR_W    = 9,
    localparam int REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_kind,
    input  logic [2:0]           cmd_op,
    input  logic [REG_IDX_W-1:0] cmd_ra,
    input  logic [REG_IDX_W-1:0] cmd_rb,
    input  logic [REG_IDX_W-1:0] cmd_rc,
    input  logic [IMM_W-1:0]     cmd_imm,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic                 mem_ready,
    output logic                 busy,
    output logic                 done,
    input  logic [REG_IDX_W:0]   dbg_sel,
    output logic [DATA_W-1:0]    dbg_data
);

    localparam logic [REG_IDX_W:0] SEL_HI = (REG_IDX_W+1)'(NUM_REGS + DBG_HI_OFS);
    localparam logic [REG_IDX_W:0] SEL_LO = (REG_IDX_W+1)'(NUM_REGS + DBG_LO_OFS);

    state_e                           state_q, state_d;
    cmd_kind_e                        kind_q;
    logic [2:0]                       op_q;
    logic [REG_IDX_W-1:0]             ra_q, rb_q, rc_q;
    logic [IMM_W-1:0]                 imm_q;
    logic [NUM_REGS-1:0][DATA_W-1:0]  gpr_q;
    logic [DATA_W-1:0]                y_q, hi_q, lo_q, mdr_q;
    logic [2*DATA_W-1:0]              z_q;
    logic [ADDR_W-1:0]                mar_q;

    logic [DATA_W-1:0]   bus;
    logic [DATA_W-1:0]   imm_sext;
    logic [2:0]          alu_op;
    logic [2*DATA_W-1:0] alu_z;
    logic                accept, is_mem, is_mul;

    assign accept   = cmd_valid && cmd_ready;
    assign is_mem   = (kind_q == KIND_LOAD) || (kind_q == KIND_STORE);
    assign is_mul   = (kind_q == KIND_ALU) && (op_q == OP_MUL);
    assign imm_sext = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    assign alu_op   = (kind_q == KIND_ALU) ? op_q : OP_ADD;

    // The one shared bus: whichever source the current micro-step drives.
    always_comb begin
        bus = '0;
        case (state_q)
            S_T1:    bus = (kind_q != KIND_ALU && rb_q == '0) ? '0 : gpr_q[rb_q];
            S_T2:    bus = (kind_q == KIND_ALU) ? gpr_q[rc_q] : imm_sext;
            S_T3:    bus = is_mem ? gpr_q[ra_q] : z_q[DATA_W-1:0];
            S_T5:    bus = mdr_q;
            default: bus = '0;
        endcase
    end

    seq_bus_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i (alu_op),
        .a_i  (y_q),
        .b_i  (bus),
        .z_o  (alu_z)
    );

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: if (accept) state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_mem) begin
                    state_d = S_MEM;
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (kind_q == KIND_LOAD) begin
                        state_d = S_T5;
                    end else begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_T5: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            kind_q  <= KIND_ALU;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            imm_q   <= '0;
            gpr_q   <= '0;
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                kind_q <= cmd_kind_e'(cmd_kind);
                op_q   <= cmd_op;
                ra_q   <= cmd_ra;
                rb_q   <= cmd_rb;
                rc_q   <= cmd_rc;
                imm_q  <= cmd_imm;
            end
            case (state_q)
                S_T1: y_q <= bus;
                S_T2: z_q <= alu_z;
                S_T3: begin
                    if (is_mem) begin
                        mar_q <= z_q[ADDR_W-1:0];
                        if (kind_q == KIND_STORE) mdr_q <= bus;
                    end else if (is_mul) begin
                        hi_q <= z_q[2*DATA_W-1:DATA_W];
                        lo_q <= z_q[DATA_W-1:0];
                    end else begin
                        gpr_q[ra_q] <= bus;
                    end
                end
                S_MEM: if (mem_ready && kind_q == KIND_LOAD) mdr_q <= mem_rdata;
                S_T5:  gpr_q[ra_q] <= bus;
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state register so clear drops them at once.
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign mem_read  = (state_q == S_MEM) && (kind_q == KIND_LOAD);
    assign mem_write = (state_q == S_MEM) && (kind_q == KIND_STORE);
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;

    always_comb begin
        dbg_data = '0;
        if (!dbg_sel[REG_IDX_W])  dbg_data = gpr_q[dbg_sel[REG_IDX_W-1:0]];
        else if (dbg_sel == SEL_HI) dbg_data = hi_q;
        else if (dbg_sel == SEL_LO) dbg_data = lo_q;
    end

endmodule
